comma_aligner_mopshub: RTL
==========================

Name: comma_aligner_mopshub

Overview:
- Word-alignment stage directly upstream of the 8b/10b decoder.
- Takes the recovered serial bitstream one bit per strobe and shifts it into a 10-bit window.
- Hunts for the K28.5 comma in either running disparity, locks the word boundary to it, and emits aligned 10-bit code groups with a one-cycle valid.
- Outputs connect straight to the decoder's datain/datain_valid.

Parameters:
- COMMA_N, 10'b0011111010, K28.5 RD- pattern (abcdeifghj order, a = MSB).
- COMMA_P, 10'b1100000101, K28.5 RD+ pattern.
- LOCK_CNT, 3, aligned commas (including the first) needed to declare lock; range 1..15.
- LOS_CNT, 2, consecutive misaligned commas in LOCKED that force a re-hunt; range 1..15.
- TIMEOUT_WORDS, 1023, words without an aligned comma before lock is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- bit_in  in  1  serial data bit; the first-transmitted bit of a code group is 'a'.
- bit_valid  in  1  strobe; bit_in is sampled when high.
- dataout  out  10  aligned code group; [9] = a, [0] = j.
- dataout_valid  out  1  one-cycle pulse per aligned word.
- comma_o  out  1  qualifies dataout_valid; the word is COMMA_N or COMMA_P.
- locked  out  1  high in LOCKED state.
- realign  out  1  one-cycle pulse when the boundary is (re)set from a comma.

Behaviour:
- Reset:
  - Asynchronous, active-low: rst low clears everything immediately, regardless of clk.
  - State = HUNT; shift register, phase, good/miss/timeout counters = 0.
  - dataout = 0; dataout_valid, comma_o, locked, realign = 0.
- Window:
  - win_next = {sr[8:0], bit_in}, evaluated combinationally.
  - On bit_valid: sr <= win_next.
  - match = (win_next == COMMA_N) or (win_next == COMMA_P).
  - Nothing changes state on cycles with bit_valid low; all outputs except locked return to 0 that cycle.
- Phase counter:
  - Counts 0..9 on each bit_valid and wraps 9 -> 0.
  - boundary = bit_valid and phase == 9.
- Word output:
  - Happens on a boundary cycle when state != HUNT.
  - Registers dataout <= win_next, dataout_valid <= 1, comma_o <= match.
  - Latency: outputs are valid the cycle after the bit_valid that carried bit j.
- HUNT:
  - On bit_valid and match at any phase: phase <= 0, good_cnt <= 1, realign pulse.
  - The comma word is emitted as an aligned word with comma_o = 1.
  - Next state: VERIFY, or LOCKED directly if LOCK_CNT == 1.
  - No words are emitted while in HUNT.
- VERIFY:
  - Boundary with match: good_cnt += 1; when it reaches LOCK_CNT -> LOCKED.
  - Boundary without match: word emitted with comma_o = 0; no count change.
  - bit_valid with match at a non-boundary phase: realign immediately as in HUNT (phase <= 0, good_cnt <= 1, realign pulse, comma word emitted); stay in VERIFY.
- LOCKED:
  - locked = 1.
  - Aligned comma: miss_cnt <= 0, to_cnt <= 0.
  - Misaligned comma (match at non-boundary phase): miss_cnt += 1, boundary unchanged.
  - When miss_cnt reaches LOS_CNT -> HUNT, locked <= 0, counters cleared.
  - to_cnt increments on every boundary without a comma. If TIMEOUT_WORDS != 0 and to_cnt reaches TIMEOUT_WORDS -> HUNT.
- Simultaneous events:
  - A boundary match is always treated as aligned; it never counts as a miss.
  - A miss and a timeout on the same cycle produce a single transition to HUNT.
  - The word that triggers the LOCKED -> HUNT exit is still emitted.
  - In HUNT, the cycle after exiting, a fresh match realigns on the next matching window.
- Counter widths: 4 bits for good_cnt/miss_cnt; to_cnt sized by $clog2(TIMEOUT_WORDS+1).
  - Saturation is not needed because of the parameter ranges.
- Reset mid-word: state is discarded and hunting restarts. A partial word is never emitted.

Test Plan:
- Reset, then bit_valid every cycle with 37 random bits not containing a comma -> dataout_valid never asserts; locked = 0.
- 3 random bits, then 0011111010, then D21.5 words (1010101010) and commas repeating -> realign pulse 1 cycle after the comma's last bit, first dataout = 0x0FA with comma_o = 1; locked rises on the 3rd aligned comma; dataout_valid is spaced exactly 10 bit strobes apart.
- Locked stream with bit_valid toggling every other cycle -> identical words; dataout_valid only in the cycle after the strobe carrying bit j.
- Locked stream with one bit slipped (11 bits between words) so commas arrive 1 bit late -> one misaligned comma keeps lock; the second sets locked = 0; the next comma gives realign and re-lock after 3 commas at the new phase.
- TIMEOUT_WORDS = 8, locked, then 8 non-comma words -> locked drops the cycle after the 8th word's output.
- Assert rst for 1 cycle at phase 5 of a word in LOCKED -> all outputs 0 immediately (asynchronous); resume only after a new comma with a realign pulse.

Source files
------------

// File: rtl/comma_aligner_mopshub.sv
// Word aligner ahead of the 8b/10b decoder: shifts in serial bits, hunts for the K28.5
// comma in either disparity, locks the word boundary and emits aligned 10-bit code groups.
module comma_aligner_mopshub #(
    parameter logic [9:0] COMMA_N       = 10'b0011111010,
    parameter logic [9:0] COMMA_P       = 10'b1100000101,
    parameter int         LOCK_CNT      = 3,
    parameter int         LOS_CNT       = 2,
    parameter int         TIMEOUT_WORDS = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [9:0] dataout,
    output logic       dataout_valid,
    output logic       comma_o,
    output logic       locked,
    output logic       realign
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int              TO_W     = (TIMEOUT_WORDS > 0) ? $clog2(TIMEOUT_WORDS + 1) : 1;
    localparam logic [3:0]      LOCK_MAX = 4'(LOCK_CNT);
    localparam logic [3:0]      LOS_MAX  = 4'(LOS_CNT);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_WORDS);
    localparam bit              TO_EN    = (TIMEOUT_WORDS != 0);

    state_t          state_r;
    logic [8:0]      sr_r;
    logic [3:0]      phase_r;
    logic [3:0]      good_r;
    logic [3:0]      miss_r;
    logic [TO_W-1:0] to_r;

    logic [9:0]      win_next_s;
    logic            match_s;
    logic            boundary_s;
    logic [3:0]      phase_inc_s;
    logic [3:0]      good_inc_s;
    logic [3:0]      miss_inc_s;
    logic [TO_W-1:0] to_inc_s;

    // Window as it will look after this strobe, plus next-value helpers for the counters.
    always_comb begin
        win_next_s  = {sr_r, bit_in};
        match_s     = (win_next_s == COMMA_N) || (win_next_s == COMMA_P);
        boundary_s  = bit_valid && (phase_r == 4'd9);
        phase_inc_s = (phase_r == 4'd9) ? 4'd0 : (phase_r + 4'd1);
        good_inc_s  = good_r + 4'd1;
        miss_inc_s  = miss_r + 4'd1;
        to_inc_s    = to_r + 1'b1;
    end

    // Alignment FSM with registered word outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= HUNT;
            sr_r          <= 9'd0;
            phase_r       <= 4'd0;
            good_r        <= 4'd0;
            miss_r        <= 4'd0;
            to_r          <= '0;
            dataout       <= 10'd0;
            dataout_valid <= 1'b0;
            comma_o       <= 1'b0;
            locked        <= 1'b0;
            realign       <= 1'b0;
        end else begin
            dataout       <= 10'd0;
            dataout_valid <= 1'b0;
            comma_o       <= 1'b0;
            realign       <= 1'b0;
            if (bit_valid) begin
                sr_r    <= win_next_s[8:0];
                phase_r <= phase_inc_s;
                case (state_r)
                    HUNT: begin
                        if (match_s) begin
                            phase_r       <= 4'd0;
                            good_r        <= 4'd1;
                            miss_r        <= 4'd0;
                            to_r          <= '0;
                            realign       <= 1'b1;
                            dataout       <= win_next_s;
                            dataout_valid <= 1'b1;
                            comma_o       <= 1'b1;
                            state_r       <= (LOCK_MAX == 4'd1) ? LOCKED : VERIFY;
                            locked        <= (LOCK_MAX == 4'd1);
                        end else begin
                            state_r <= HUNT;
                        end
                    end
                    VERIFY: begin
                        if (boundary_s) begin
                            dataout       <= win_next_s;
                            dataout_valid <= 1'b1;
                            comma_o       <= match_s;
                            if (match_s) begin
                                good_r <= good_inc_s;
                                if (good_inc_s == LOCK_MAX) begin
                                    state_r <= LOCKED;
                                    locked  <= 1'b1;
                                    miss_r  <= 4'd0;
                                    to_r    <= '0;
                                end else begin
                                    state_r <= VERIFY;
                                end
                            end else begin
                                state_r <= VERIFY;
                            end
                        end else if (match_s) begin
                            // Comma off the tentative boundary: restart verification here.
                            phase_r       <= 4'd0;
                            good_r        <= 4'd1;
                            realign       <= 1'b1;
                            dataout       <= win_next_s;
                            dataout_valid <= 1'b1;
                            comma_o       <= 1'b1;
                        end else begin
                            state_r <= VERIFY;
                        end
                    end
                    LOCKED: begin
                        if (boundary_s) begin
                            dataout       <= win_next_s;
                            dataout_valid <= 1'b1;
                            comma_o       <= match_s;
                            if (match_s) begin
                                miss_r <= 4'd0;
                                to_r   <= '0;
                            end else if (TO_EN && (to_inc_s == TO_MAX)) begin
                                state_r <= HUNT;
                                locked  <= 1'b0;
                                good_r  <= 4'd0;
                                miss_r  <= 4'd0;
                                to_r    <= '0;
                            end else begin
                                to_r <= to_inc_s;
                            end
                        end else if (match_s) begin
                            if (miss_inc_s == LOS_MAX) begin
                                state_r <= HUNT;
                                locked  <= 1'b0;
                                good_r  <= 4'd0;
                                miss_r  <= 4'd0;
                                to_r    <= '0;
                            end else begin
                                miss_r <= miss_inc_s;
                            end
                        end else begin
                            state_r <= LOCKED;
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
